// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_if
//  Description : Control/handshake bundle between the multi-cycle MIPS control
//                FSM (master) and the datapath plus shared memory port (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;
    logic [2:0] opcode;
    logic [3:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       halted;
    logic [1:0] fault_code;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src_b, alu_op, halted, fault_code, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src_b, alu_op, halted, fault_code, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Multi-cycle control FSM for the 16-bit MIPS core, owning the
//                shared memory port handshake and its access timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mc_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,  S_WB_ALU = 4'd5, S_MADDR = 4'd6,   S_MRD    = 4'd7,
        S_MWB    = 4'd8,  S_MWR   = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_FAULT  = 4'd12, S_STOP  = 4'd13
    } state_t;

    localparam logic [3:0] c_ALU_ADD    = 4'b0000;
    localparam logic [3:0] c_ALU_SUB    = 4'b0001;
    localparam logic [1:0] c_FC_FUNCT   = 2'b01;
    localparam logic [1:0] c_FC_TIMEOUT = 2'b10;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       w_next_fault;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mem_state;
    logic             w_timeout;

    logic       r_mem_req, r_mem_we, r_iord, r_pc_we, r_reg_we, r_reg_dst;
    logic       r_mem_to_reg, r_alu_src_b, r_halted, r_bne;
    logic [1:0] r_pc_src, r_fault_code;
    logic [3:0] r_alu_op;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MRD) || (r_state == S_MWR);
    // Last permitted wait cycle: a ready in this cycle still completes the access.
    assign w_timeout   = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_next       = r_state;
        w_next_fault = 2'b00;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH, S_MRD, S_MWR: begin
                if (bus.mem_ready) begin
                    if (r_state == S_FETCH)    w_next = S_DECODE;
                    else if (r_state == S_MRD) w_next = S_MWB;
                    else                       w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_FAULT;
                    w_next_fault = c_FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    3'b000: begin
                        if (bus.funct[3]) begin
                            w_next       = S_FAULT;
                            w_next_fault = c_FC_FUNCT;
                        end else begin
                            w_next = S_EXEC_R;
                        end
                    end
                    3'b001:         w_next = S_EXEC_I;
                    3'b010, 3'b011: w_next = S_MADDR;
                    3'b100, 3'b101: w_next = S_BRANCH;
                    3'b110:         w_next = S_JUMP;
                    default:        w_next = S_STOP;
                endcase
            end
            S_EXEC_R, S_EXEC_I:                   w_next = S_WB_ALU;
            S_WB_ALU, S_MWB, S_BRANCH, S_JUMP:    w_next = S_FETCH;
            S_MADDR: w_next = bus.opcode[0] ? S_MWR : S_MRD;
            S_FAULT, S_STOP:                      w_next = r_state;
            default:                              w_next = S_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_iord       <= 1'b0;
            r_pc_we      <= 1'b0;
            r_pc_src     <= 2'b00;
            r_reg_we     <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src_b  <= 1'b0;
            r_alu_op     <= 4'b0000;
            r_halted     <= 1'b0;
            r_bne        <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_mem_state && !bus.mem_ready && (w_next == r_state))
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_iord       <= 1'b0;
            r_pc_we      <= 1'b0;
            r_pc_src     <= 2'b00;
            r_reg_we     <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src_b  <= 1'b0;
            r_alu_op     <= 4'b0000;
            r_halted     <= 1'b0;
            r_bne        <= 1'b0;
            case (w_next)
                S_FETCH:  r_mem_req <= 1'b1;
                S_EXEC_R: r_alu_op  <= bus.funct;
                S_EXEC_I, S_MADDR: begin
                    r_alu_op    <= c_ALU_ADD;
                    r_alu_src_b <= 1'b1;
                end
                S_WB_ALU: begin
                    r_reg_we    <= 1'b1;
                    r_reg_dst   <= (bus.opcode == 3'b000);
                    r_alu_op    <= r_alu_op;
                    r_alu_src_b <= r_alu_src_b;
                end
                S_MRD: begin
                    r_mem_req <= 1'b1;
                    r_iord    <= 1'b1;
                end
                S_MWB: begin
                    r_reg_we     <= 1'b1;
                    r_mem_to_reg <= 1'b1;
                end
                S_MWR: begin
                    r_mem_req <= 1'b1;
                    r_mem_we  <= 1'b1;
                    r_iord    <= 1'b1;
                end
                S_BRANCH: begin
                    r_alu_op <= c_ALU_SUB;
                    r_pc_src <= 2'b01;
                    r_bne    <= bus.opcode[0];
                end
                S_JUMP: begin
                    r_pc_we  <= 1'b1;
                    r_pc_src <= 2'b10;
                end
                S_FAULT:  r_halted <= 1'b1;
                default:  ;
            endcase
            if ((w_next == S_FAULT) && (r_state != S_FAULT))
                r_fault_code <= w_next_fault;
        end
    end

    // Fetch completion and branch decision depend on this cycle's ready/zero.
    assign bus.ir_we      = (r_state == S_FETCH) & bus.mem_ready;
    assign bus.pc_we      = r_pc_we | ((r_state == S_FETCH) & bus.mem_ready)
                          | ((r_state == S_BRANCH) & (bus.zero ^ r_bne));
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.iord       = r_iord;
    assign bus.pc_src     = r_pc_src;
    assign bus.reg_we     = r_reg_we;
    assign bus.reg_dst    = r_reg_dst;
    assign bus.mem_to_reg = r_mem_to_reg;
    assign bus.alu_src_b  = r_alu_src_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.halted     = r_halted;
    assign bus.fault_code = r_fault_code;
    assign bus.state_dbg  = r_state;
endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl_fsm
//  Description : Self-checking bench for mc_ctrl_fsm using per-cycle vector
//                tables and an expected-output queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst_n;

    mc_ctrl_if bus ();

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {state, req,we,iord, ir_we,pc_we,pc_src, reg_we,reg_dst,m2r, srcb, alu_op, halted,fc}
    typedef struct {
        logic [2:0]  op;
        logic [3:0]  fn;
        logic        z;
        logic        rdy;
        logic [21:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [21:0] exp;
        string       name;
    } sb_t;

    vec_t tbl[$];
    sb_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [21:0] outs();
        return {bus.state_dbg, bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we,
                bus.pc_src, bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_b,
                bus.alu_op, bus.halted, bus.fault_code};
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = outs();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %06h expected %06h", name, act, exp);
    endtask

    task automatic add(input logic [2:0] op, input logic [3:0] fn, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [2:0] mem,
                       input logic [3:0] pc, input logic [2:0] rg, input logic srcb,
                       input logic [3:0] alu, input logic [2:0] hf, input string name);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.exp = {st, mem, pc, rg, srcb, alu, hf};
        v.name = name;
        tbl.push_back(v);
    endtask

    // Drive one cycle's inputs after the edge, queue its expectation, check mid-cycle.
    task automatic run_table();
        sb_t s;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            bus.opcode = tbl[i].op; bus.funct = tbl[i].fn;
            bus.zero = tbl[i].z;    bus.mem_ready = tbl[i].rdy;
            s.exp = tbl[i].exp; s.name = $sformatf("%s[%0d]", tbl[i].name, i);
            exp_q.push_back(s);
            @(negedge clk);
            s = exp_q.pop_front();
            check(s.name, s.exp);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 22'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 22'h0);
    endtask

    // Frequently used expected patterns
    task automatic fetch(input logic [2:0] op, input logic rdy);
        add(op, 4'h1, 1'b0, rdy, 4'd1, 3'b100, rdy ? 4'b1100 : 4'b0000, 3'b000, 1'b0, 4'h0, 3'b000, "fetch");
    endtask
    task automatic decode(input logic [2:0] op, input logic [3:0] fn);
        add(op, fn, 1'b0, 1'b1, 4'd2, 3'b000, 4'b0000, 3'b000, 1'b0, 4'h0, 3'b000, "decode");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = 3'b000; bus.funct = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        // Full instruction mix
        do_reset();
        fetch(3'b000, 1'b1);
        decode(3'b000, 4'b0001);
        add(3'b000, 4'b0001, 0, 1, 4'd3,  3'b000, 4'b0000, 3'b000, 0, 4'h1, 3'b000, "exec_r_sub");
        add(3'b000, 4'b0001, 0, 1, 4'd5,  3'b000, 4'b0000, 3'b110, 0, 4'h1, 3'b000, "wb_r");
        fetch(3'b000, 1'b0);
        fetch(3'b000, 1'b1);
        decode(3'b000, 4'b0111);
        add(3'b000, 4'b0111, 0, 1, 4'd3,  3'b000, 4'b0000, 3'b000, 0, 4'h7, 3'b000, "exec_r_srl");
        add(3'b000, 4'b0111, 0, 1, 4'd5,  3'b000, 4'b0000, 3'b110, 0, 4'h7, 3'b000, "wb_r_srl");
        fetch(3'b010, 1'b1);
        decode(3'b010, 4'h0);
        add(3'b010, 4'h0, 0, 1, 4'd6,  3'b000, 4'b0000, 3'b000, 1, 4'h0, 3'b000, "maddr_lw");
        for (int k = 0; k < 3; k++)
            add(3'b010, 4'h0, 0, 0, 4'd7, 3'b101, 4'b0000, 3'b000, 0, 4'h0, 3'b000, "mrd_wait");
        add(3'b010, 4'h0, 0, 1, 4'd7,  3'b101, 4'b0000, 3'b000, 0, 4'h0, 3'b000, "mrd_done");
        add(3'b010, 4'h0, 0, 1, 4'd8,  3'b000, 4'b0000, 3'b101, 0, 4'h0, 3'b000, "mwb");
        fetch(3'b011, 1'b1);
        decode(3'b011, 4'h0);
        add(3'b011, 4'h0, 0, 1, 4'd6,  3'b000, 4'b0000, 3'b000, 1, 4'h0, 3'b000, "maddr_sw");
        add(3'b011, 4'h0, 0, 1, 4'd9,  3'b111, 4'b0000, 3'b000, 0, 4'h0, 3'b000, "mwr");
        fetch(3'b001, 1'b1);
        decode(3'b001, 4'h0);
        add(3'b001, 4'h0, 0, 1, 4'd4,  3'b000, 4'b0000, 3'b000, 1, 4'h0, 3'b000, "exec_i");
        add(3'b001, 4'h0, 0, 1, 4'd5,  3'b000, 4'b0000, 3'b100, 1, 4'h0, 3'b000, "wb_i");
        fetch(3'b100, 1'b1);
        decode(3'b100, 4'h0);
        add(3'b100, 4'h0, 1, 1, 4'd10, 3'b000, 4'b0101, 3'b000, 0, 4'h1, 3'b000, "beq_taken");
        fetch(3'b101, 1'b1);
        decode(3'b101, 4'h0);
        add(3'b101, 4'h0, 1, 1, 4'd10, 3'b000, 4'b0001, 3'b000, 0, 4'h1, 3'b000, "bne_not_taken");
        fetch(3'b101, 1'b1);
        decode(3'b101, 4'h0);
        add(3'b101, 4'h0, 0, 1, 4'd10, 3'b000, 4'b0101, 3'b000, 0, 4'h1, 3'b000, "bne_taken");
        fetch(3'b100, 1'b1);
        decode(3'b100, 4'h0);
        add(3'b100, 4'h0, 0, 1, 4'd10, 3'b000, 4'b0001, 3'b000, 0, 4'h1, 3'b000, "beq_not_taken");
        fetch(3'b110, 1'b1);
        decode(3'b110, 4'h0);
        add(3'b110, 4'h0, 0, 1, 4'd11, 3'b000, 4'b0110, 3'b000, 0, 4'h0, 3'b000, "jump");
        fetch(3'b111, 1'b1);
        decode(3'b111, 4'h0);
        add(3'b111, 4'h0, 0, 0, 4'd13, 3'b000, 4'b0000, 3'b000, 0, 4'h0, 3'b000, "stop");
        add(3'b111, 4'h0, 0, 1, 4'd13, 3'b000, 4'b0000, 3'b000, 0, 4'h0, 3'b000, "stop_hold");
        run_table();

        // Illegal R-type funct
        do_reset();
        fetch(3'b000, 1'b1);
        decode(3'b000, 4'b1010);
        for (int k = 0; k < 3; k++)
            add(3'b000, 4'b1010, 0, 1, 4'd12, 3'b000, 4'b0000, 3'b000, 0, 4'h0, 3'b101, "fault_funct");
        run_table();

        // Fetch timeout: 16 waiting cycles then FAULT(10)
        do_reset();
        for (int k = 0; k < 16; k++) fetch(3'b000, 1'b0);
        for (int k = 0; k < 2; k++)
            add(3'b000, 4'h0, 0, 1, 4'd12, 3'b000, 4'b0000, 3'b000, 0, 4'h0, 3'b110, "fault_timeout");
        run_table();

        // Ready arriving on the 16th cycle completes the fetch
        do_reset();
        for (int k = 0; k < 15; k++) fetch(3'b001, 1'b0);
        fetch(3'b001, 1'b1);
        decode(3'b001, 4'h0);
        add(3'b001, 4'h0, 0, 1, 4'd4, 3'b000, 4'b0000, 3'b000, 1, 4'h0, 3'b000, "exec_i_after_late");
        run_table();

        // Asynchronous reset in the middle of a store wait
        do_reset();
        fetch(3'b011, 1'b1);
        decode(3'b011, 4'h0);
        add(3'b011, 4'h0, 0, 1, 4'd6, 3'b000, 4'b0000, 3'b000, 1, 4'h0, 3'b000, "maddr_sw2");
        for (int k = 0; k < 2; k++)
            add(3'b011, 4'h0, 0, 0, 4'd9, 3'b111, 4'b0000, 3'b000, 0, 4'h0, 3'b000, "mwr_wait");
        run_table();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_mwr", 22'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_async", 22'h0);
        fetch(3'b011, 1'b1);
        run_table();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
